score_event_arbiter: RTL and testbench

- Shares the single 3-digit BCD points accumulator of the scoreboard between NUM_REQ independent hit sensors (targets).
- Detects hit edges, queues them per requester, grants the adder round-robin, and applies +PTS_NORMAL or +PTS_BONUS (late-phase flag) with saturation at 999.
- Sits between the raw target inputs and the score/level/timer controller, replacing the per-event Add2/Add3 strobes with one serialized update path.

---
 rtl/score_pkg.sv | 22 ++
 rtl/bcd_add3.sv | 32 +++
 rtl/score_event_arbiter.sv | 174 +++++++++++++++++
 tb/tb_score_event_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types for the scoreboard points path.
// BCD score digits, FSM states and the saturation ceiling.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t h;
    bcd_digit_t t;
    bcd_digit_t o;
  } bcd_score_t;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ADD,
    WRITE
  } state_e;

  localparam logic [11:0] MAX_SCORE_BCD = 12'h999;

endpackage

// File: rtl/bcd_add3.sv
// 3-digit BCD plus single BCD digit adder.
// Clamps to 999 and flags sat on carry out of the hundreds digit.
module bcd_add3
  import score_pkg::*;
(
  input  bcd_score_t a,
  input  bcd_digit_t b,
  output bcd_score_t sum,
  output logic       sat
);

  logic [4:0] o_s, t_s, h_s;
  logic       o_c, t_c, h_c;
  bcd_digit_t o_d, t_d, h_d;

  assign o_s = {1'b0, a.o} + {1'b0, b};
  assign o_c = o_s > 5'd9;
  assign o_d = o_c ? 4'(o_s - 5'd10) : o_s[3:0];

  assign t_s = {1'b0, a.t} + {4'b0, o_c};
  assign t_c = t_s > 5'd9;
  assign t_d = t_c ? 4'(t_s - 5'd10) : t_s[3:0];

  assign h_s = {1'b0, a.h} + {4'b0, t_c};
  assign h_c = h_s > 5'd9;
  assign h_d = h_c ? 4'(h_s - 5'd10) : h_s[3:0];

  assign sat = h_c;
  assign sum = h_c ? bcd_score_t'(MAX_SCORE_BCD)
                   : bcd_score_t'({h_d, t_d, o_d});

endmodule

// File: rtl/score_event_arbiter.sv
// Serialises target hits onto the single BCD score adder.
// Per-target pending queues, round-robin grant, 3-cycle update.
module score_event_arbiter
  import score_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int PEND_W     = 2,
  parameter int PTS_NORMAL = 2,
  parameter int PTS_BONUS  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr_score,
  input  logic               bonus,
  input  logic [NUM_REQ-1:0] hit,
  output logic [NUM_REQ-1:0] grant,
  output logic               upd_valid,
  output logic [11:0]        score_bcd,
  output logic               sat,
  output logic [NUM_REQ-1:0] drop,
  output logic               busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  state_e state_q, state_d;
  logic [NUM_REQ-1:0] hit_q;
  logic [NUM_REQ-1:0][PEND_W-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] drop_q, drop_d;
  logic [NUM_REQ-1:0] ev, pend_nz;
  logic [IW-1:0] last_q, last_d, pick;
  logic found, any_pend;
  bcd_digit_t amt_q, amt_d;
  bcd_score_t score_q, score_d;
  bcd_score_t sum_q, sum_d, add_sum;
  logic add_sat, ovf_q, ovf_d;
  logic sat_q, sat_d, upd_q, upd_d;

  assign ev = hit & ~hit_q & {NUM_REQ{en}};

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_nz[i] = |pend_q[i];
    end
  end

  assign any_pend = |pend_nz;

  // Search starts one past the last winner
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_q) + 1 + k) % NUM_REQ;
      if (!found && pend_nz[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  bcd_add3 u_add (
    .a   (score_q),
    .b   (amt_q),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_comb begin
    state_d = state_q;
    grant   = '0;
    last_d  = last_q;
    amt_d   = amt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    score_d = score_q;
    sat_d   = sat_q;
    upd_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_pend) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          grant[pick] = 1'b1;
          last_d      = pick;
          amt_d       = bonus ? bcd_digit_t'(PTS_BONUS)
                              : bcd_digit_t'(PTS_NORMAL);
          state_d     = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        sum_d   = add_sum;
        ovf_d   = add_sat;
        state_d = WRITE;
      end
      WRITE: begin
        score_d = sum_q;
        sat_d   = sat_q | ovf_q;
        upd_d   = 1'b1;
        state_d = any_pend ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_score) begin
      state_d = IDLE;
      grant   = '0;
      last_d  = LAST_RST;
      score_d = '0;
      sat_d   = 1'b0;
      upd_d   = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_d[i] = pend_q[i];
      drop_d[i] = drop_q[i];
      if (clr_score) begin
        pend_d[i] = '0;
        drop_d[i] = 1'b0;
      end else if (!en) begin
        pend_d[i] = '0;
      end else if (ev[i] && !grant[i]) begin
        if (pend_q[i] == PEND_MAX) drop_d[i] = 1'b1;
        else pend_d[i] = pend_q[i] + 1'b1;
      end else if (!ev[i] && grant[i]) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hit_q   <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
      last_q  <= LAST_RST;
      amt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      score_q <= '0;
      sat_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      last_q  <= last_d;
      amt_q   <= amt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      score_q <= score_d;
      sat_q   <= sat_d;
      upd_q   <= upd_d;
    end
  end

  assign score_bcd = score_q;
  assign upd_valid = upd_q;
  assign sat       = sat_q;
  assign drop      = drop_q;
  assign busy      = (state_q != IDLE) | any_pend;

endmodule

// File: tb/tb_score_event_arbiter.sv
// Directed bench for score_event_arbiter.
// Cycle table for basic flow plus hand sequences for corners.
module tb_score_event_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, en, clr_score, bonus;
  logic [3:0]  hit, grant, drop;
  logic        upd_valid, sat, busy;
  logic [11:0] score_bcd;

  int checks = 0;
  int errors = 0;
  int gcnt[4];
  int upd_cnt = 0;
  int multi_cnt = 0;

  always #5 clk = ~clk;

  score_event_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr_score (clr_score),
    .bonus     (bonus),
    .hit       (hit),
    .grant     (grant),
    .upd_valid (upd_valid),
    .score_bcd (score_bcd),
    .sat       (sat),
    .drop      (drop),
    .busy      (busy)
  );

  initial for (int i = 0; i < 4; i++) gcnt[i] = 0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) gcnt[i] += int'(grant[i]);
      upd_cnt += int'(upd_valid);
      if ($countones(grant) > 1) multi_cnt++;
    end
  end

  typedef struct packed {
    logic        clr;
    logic        en;
    logic        bonus;
    logic [3:0]  hit;
    logic [3:0]  g;
    logic        upd;
    logic [11:0] score;
    logic        sat;
    logic        busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic c, e, b,
                              input logic [3:0] h, g,
                              input logic u,
                              input logic [11:0] s,
                              input logic st, by);
    vec_t r;
    r.clr = c; r.en = e; r.bonus = b; r.hit = h;
    r.g = g; r.upd = u; r.score = s; r.sat = st; r.busy = by;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic pulse(input logic [3:0] h, input logic b);
    @(negedge clk);
    hit = h;
    bonus = b;
    @(negedge clk);
    hit = '0;
    wait_idle();
  endtask

  int g_base[4];
  int u_base;

  task automatic snap();
    for (int i = 0; i < 4; i++) g_base[i] = gcnt[i];
    u_base = upd_cnt;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_score = 1'b0;
    bonus = 1'b0; hit = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_score", 32'(score_bcd), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_upd", 32'(upd_valid), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single hit, then clear and 4 simultaneous bonus hits, then en flush
    tv.push_back(mk(0,1,0,4'b0000, 4'b0000,0,12'h000,0,0));
    tv.push_back(mk(0,1,0,4'b0001, 4'b0000,0,12'h000,0,1));
    tv.push_back(mk(0,1,0,4'b0001, 4'b0001,0,12'h000,0,1));
    tv.push_back(mk(0,1,0,4'b0000, 4'b0000,0,12'h000,0,1));
    tv.push_back(mk(0,1,0,4'b0000, 4'b0000,0,12'h000,0,1));
    tv.push_back(mk(0,1,0,4'b0000, 4'b0000,1,12'h002,0,0));
    tv.push_back(mk(0,1,0,4'b0000, 4'b0000,0,12'h002,0,0));
    tv.push_back(mk(1,1,0,4'b0000, 4'b0000,0,12'h000,0,0));
    tv.push_back(mk(0,1,1,4'b1111, 4'b0000,0,12'h000,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0001,0,12'h000,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,0,12'h000,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,0,12'h000,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0010,1,12'h003,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,0,12'h003,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,0,12'h003,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0100,1,12'h006,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,0,12'h006,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,0,12'h006,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b1000,1,12'h009,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,0,12'h009,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,0,12'h009,0,1));
    tv.push_back(mk(0,1,1,4'b0000, 4'b0000,1,12'h012,0,0));
    tv.push_back(mk(0,1,0,4'b0000, 4'b0000,0,12'h012,0,0));
    tv.push_back(mk(0,1,0,4'b1111, 4'b0000,0,12'h012,0,1));
    tv.push_back(mk(0,0,0,4'b0000, 4'b0000,0,12'h012,0,1));
    tv.push_back(mk(0,0,0,4'b0000, 4'b0000,0,12'h012,0,0));
    tv.push_back(mk(0,1,0,4'b0000, 4'b0000,0,12'h012,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      clr_score = tv[i].clr; en = tv[i].en;
      bonus = tv[i].bonus; hit = tv[i].hit;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tv[i].g));
      chk($sformatf("v%0d_upd", i), 32'(upd_valid), 32'(tv[i].upd));
      chk($sformatf("v%0d_score", i), 32'(score_bcd), 32'(tv[i].score));
      chk($sformatf("v%0d_sat", i), 32'(sat), 32'(tv[i].sat));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
    end

    // saturation: 332 * 3 = 996, +3 exact, +2 overflows
    @(negedge clk);
    clr_score = 1'b1;
    @(negedge clk);
    clr_score = 1'b0;
    for (int i = 0; i < 332; i++) pulse(4'b0001, 1'b1);
    chk("pre_996", 32'(score_bcd), 32'h996);
    chk("pre_996_sat", 32'(sat), 0);
    pulse(4'b0001, 1'b1);
    chk("exact_999", 32'(score_bcd), 32'h999);
    chk("exact_999_sat", 32'(sat), 0);
    snap();
    pulse(4'b0001, 1'b0);
    chk("ovf_999", 32'(score_bcd), 32'h999);
    chk("ovf_sat", 32'(sat), 1);
    chk("ovf_upd_cnt", 32'(upd_cnt - u_base), 1);

    // queue overflow on requester 1 while 2,3,0 are served first
    pulse(4'b0010, 1'b0);
    snap();
    @(negedge clk); hit = 4'b1111;
    @(negedge clk); hit = 4'b0000;
    @(negedge clk); hit = 4'b0010;
    @(negedge clk); hit = 4'b0000;
    @(negedge clk); hit = 4'b0010;
    @(negedge clk); hit = 4'b0000;
    @(negedge clk); hit = 4'b0010;
    @(negedge clk); hit = 4'b0000;
    wait_idle();
    chk("drop_vec", 32'(drop), 32'b0010);
    chk("g1_cnt", 32'(gcnt[1] - g_base[1]), 3);
    chk("g0_cnt", 32'(gcnt[0] - g_base[0]), 1);
    chk("g2_cnt", 32'(gcnt[2] - g_base[2]), 1);
    chk("g3_cnt", 32'(gcnt[3] - g_base[3]), 1);
    chk("drop_upd_cnt", 32'(upd_cnt - u_base), 6);
    chk("drop_score", 32'(score_bcd), 32'h999);

    // clear while the add is in flight
    @(negedge clk); hit = 4'b0001; bonus = 1'b0;
    @(negedge clk); hit = 4'b0000;
    @(posedge clk); #1;
    chk("clr_arb_grant", 32'(grant), 32'b0001);
    @(negedge clk);
    @(posedge clk); #1;
    chk("clr_add_busy", 32'(busy), 1);
    @(negedge clk); clr_score = 1'b1;
    @(posedge clk); #1;
    chk("clr_score", 32'(score_bcd), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_sat", 32'(sat), 0);
    chk("clr_drop", 32'(drop), 0);
    chk("clr_upd", 32'(upd_valid), 0);
    @(negedge clk); clr_score = 1'b0;
    @(posedge clk); #1;
    chk("clr_no_upd", 32'(upd_valid), 0);
    chk("clr_score2", 32'(score_bcd), 0);

    // edges while disabled are not remembered
    snap();
    @(negedge clk); en = 1'b0; hit = 4'b0101;
    @(negedge clk);
    @(negedge clk); en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("en_busy", 32'(busy), 0);
    chk("en_grants", 32'(gcnt[0] + gcnt[2] - g_base[0] - g_base[2]), 0);
    chk("en_score", 32'(score_bcd), 0);
    @(negedge clk); hit = 4'b0000;
    pulse(4'b0100, 1'b0);
    chk("en_g2", 32'(gcnt[2] - g_base[2]), 1);
    chk("en_score2", 32'(score_bcd), 32'h002);

    chk("multi_hot", 32'(multi_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
